// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache: default geometry and FSM states.
package inst_cache_pkg;

  localparam int ICACHE_IDX_WID = 8;
  localparam int ICACHE_ADDR_W  = 32;
  localparam int ICACHE_DATA_W  = 32;
  localparam int ICACHE_TAG_WID = ICACHE_ADDR_W - ICACHE_IDX_WID - 2;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_t;

endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// One combinational read port, one synchronous write port; reset clears only
// the valid bits, tag and data contents are left as they are.
module icache_array
  import inst_cache_pkg::*;
#(
  parameter int IDX_WID = ICACHE_IDX_WID,
  parameter int TAG_WID = ICACHE_TAG_WID,
  parameter int DATA_W  = ICACHE_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_WID-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_WID-1:0] rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [IDX_WID-1:0] wr_idx,
  input  logic [TAG_WID-1:0] wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  localparam int LINES = 1 << IDX_WID;

  logic [LINES-1:0]   valid_q;
  logic [TAG_WID-1:0] tag_q  [LINES];
  logic [DATA_W-1:0]  data_q [LINES];

  // Valid bits: cleared by reset, set when a line is filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage: written on fill, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the
// memory controller. Hits deliver one cycle after acceptance; misses issue a
// single fetch, fill the line and forward the word. A flush only suppresses
// delivery, it never aborts a memory transaction in progress.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int IDX_WID = ICACHE_IDX_WID,
  parameter int ADDR_W  = ICACHE_ADDR_W,
  parameter int DATA_W  = ICACHE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              fe_en,
  input  logic [ADDR_W-1:0] fe_pc,
  output logic              fe_done,
  output logic [DATA_W-1:0] fe_inst,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_pc,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int TAG_WID = ADDR_W - IDX_WID - 2;

  icache_state_t state_q, state_d;

  logic              killed_q;
  logic              fe_done_q;
  logic [DATA_W-1:0] fe_inst_q;
  logic [ADDR_W-1:0] mem_pc_q;

  logic [IDX_WID-1:0] fe_idx, mem_idx;
  logic [TAG_WID-1:0] fe_tag, mem_tag;

  logic               line_valid;
  logic [TAG_WID-1:0] line_tag;
  logic [DATA_W-1:0]  line_data;

  logic hit;
  logic accept;
  logic fill;
  logic unused_pc_lo;

  assign fe_idx  = fe_pc[IDX_WID+1:2];
  assign fe_tag  = fe_pc[ADDR_W-1:IDX_WID+2];
  assign mem_idx = mem_pc_q[IDX_WID+1:2];
  assign mem_tag = mem_pc_q[ADDR_W-1:IDX_WID+2];

  assign unused_pc_lo = ^{fe_pc[1:0], mem_pc_q[1:0]};

  icache_array #(
    .IDX_WID (IDX_WID),
    .TAG_WID (TAG_WID),
    .DATA_W  (DATA_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (fe_idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (fill),
    .wr_idx   (mem_idx),
    .wr_tag   (mem_tag),
    .wr_data  (mem_data)
  );

  assign hit    = line_valid && (line_tag == fe_tag);
  // A request is not taken while the previous result is on fe_done, nor in a flush cycle.
  assign accept = (state_q == IDLE) && fe_en && !fe_done_q && !clr && rdy;
  assign fill   = (state_q == MISS) && mem_done && rdy;

  // State register; a frozen pipeline holds the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Next state and the memory request, which drops in the mem_done cycle.
  always_comb begin
    state_d = state_q;
    mem_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && !hit) begin
          state_d = MISS;
        end
      end
      MISS: begin
        mem_en = !mem_done && rdy;
        if (fill) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Delivery registers, miss address and the flush-kill flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fe_done_q <= 1'b0;
      fe_inst_q <= '0;
      mem_pc_q  <= '0;
      killed_q  <= 1'b0;
    end else if (rdy) begin
      fe_done_q <= 1'b0;
      if (accept && hit) begin
        fe_done_q <= 1'b1;
        fe_inst_q <= line_data;
      end
      if (accept && !hit) begin
        mem_pc_q <= fe_pc;
        killed_q <= 1'b0;
      end
      if ((state_q == MISS) && clr) begin
        killed_q <= 1'b1;
      end
      if (fill) begin
        fe_inst_q <= mem_data;
        fe_done_q <= !killed_q && !clr;
      end
    end
  end

  assign fe_done = fe_done_q && rdy;
  assign fe_inst = fe_inst_q;
  assign mem_pc  = mem_pc_q;

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios plus a randomized run,
// checked every cycle against a word-address level cache model.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst, rdy, clr, fe_en;
  logic [31:0] fe_pc;
  logic        fe_done;
  logic [31:0] fe_inst;
  logic        mem_en;
  logic [31:0] mem_pc;
  logic        mem_done;
  logic [31:0] mem_data;

  int vectors = 0;
  int miscompares = 0;

  // memory controller state
  bit          memBusy = 0;
  int          memCount = 0;
  logic [31:0] memReqPc = 0;
  bit          memEnSeen = 0;
  logic [31:0] memPcSeen = 0;
  int          latMin = 2;
  int          latMax = 2;

  // reference model: lines keyed by index, holding the full word address
  logic [31:0] lineAddr [int];
  logic [31:0] lineData [int];
  bit          mBusy = 0, mDone = 0, mKilled = 0, modelReady = 0, nextDone = 0;
  logic [31:0] mInst = 0, mMemPc = 0, wAddr = 0;
  int          wIdx = 0;

  int          cyc, men, cnt, doneCnt;
  logic [3:0]  pat;
  logic [31:0] curPc;
  bit          needNew;
  bit          rRst, rRdy, rClr, rEn, rInj;

  inst_cache dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .clr      (clr),
    .fe_en    (fe_en),
    .fe_pc    (fe_pc),
    .fe_done  (fe_done),
    .fe_inst  (fe_inst),
    .mem_en   (mem_en),
    .mem_pc   (mem_pc),
    .mem_done (mem_done),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] randPc();
    return 32'h0000_1000 + 32'($urandom_range(0, 2)) * 32'h400 + 32'($urandom_range(0, 3)) * 32'd4;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus: advance the memory controller, then drive the fetch side.
  task automatic applyStimulus(input logic iRst, input logic iRdy, input logic iClr,
                               input logic iFeEn, input logic [31:0] iPc, input bit iInject);
    @(posedge clk);
    #1;
    if (rst) begin
      memBusy  = 0;
      mem_done = 0;
    end else if (rdy) begin
      if (mem_done) begin
        mem_done = 0;
        memBusy  = 0;
      end else if (memBusy) begin
        if (memCount == 0) begin
          mem_done = 1;
          mem_data = memWord(memReqPc);
        end else begin
          memCount--;
        end
      end else if (memEnSeen) begin
        memBusy  = 1;
        memReqPc = memPcSeen;
        memCount = $urandom_range(latMax, latMin);
      end else if (iInject && !mBusy) begin
        mem_done = 1;
        mem_data = $urandom;
      end
    end
    rst   = iRst;
    rdy   = iRdy;
    clr   = iClr;
    fe_en = iFeEn;
    fe_pc = iPc;
  endtask

  // Hold a request until it is delivered; report cycles to delivery and memory request cycles.
  task automatic fetchOnce(input logic [31:0] pc, output int cycles, output int memEnCycles);
    cycles = -1;
    memEnCycles = 0;
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, pc, 1'b0);
      @(negedge clk);
      if (mem_en) memEnCycles++;
      if (fe_done) begin
        cycles = i;
        break;
      end
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, pc, 1'b0);
    if (cycles < 0) checkOutput("fetch timeout", 32'd0, 32'd1);
  endtask

  // Sample what the memory controller and fetcher see.
  always @(negedge clk) begin
    memEnSeen = mem_en;
    memPcSeen = mem_pc;
  end

  // Reference model update on every clock edge.
  always @(posedge clk) begin
    if (rst) begin
      lineAddr.delete();
      lineData.delete();
      mBusy = 0;
      mDone = 0;
      mKilled = 0;
      mInst = 0;
      mMemPc = 0;
      modelReady = 1;
    end else if (rdy && modelReady) begin
      nextDone = 0;
      if (!mBusy) begin
        if (fe_en && !mDone && !clr) begin
          wAddr = fe_pc >> 2;
          wIdx  = int'(wAddr % 256);
          if (lineAddr.exists(wIdx) && lineAddr[wIdx] == wAddr) begin
            nextDone = 1;
            mInst = lineData[wIdx];
          end else begin
            mBusy = 1;
            mMemPc = fe_pc;
            mKilled = 0;
          end
        end
      end else if (mem_done) begin
        wAddr = mMemPc >> 2;
        wIdx  = int'(wAddr % 256);
        lineAddr[wIdx] = wAddr;
        lineData[wIdx] = mem_data;
        mInst = mem_data;
        nextDone = !mKilled && !clr;
        mBusy = 0;
      end else if (clr) begin
        mKilled = 1;
      end
      mDone = nextDone;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("fe_done", {31'b0, fe_done}, {31'b0, mDone && rdy});
      checkOutput("mem_en", {31'b0, mem_en}, {31'b0, mBusy && !mem_done && rdy});
      checkOutput("mem_pc", mem_pc, mMemPc);
      checkOutput("fe_inst", fe_inst, mInst);
    end
  end

  initial begin
    #1_000_000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    rst = 1; rdy = 1; clr = 0; fe_en = 0; fe_pc = 0; mem_done = 0; mem_data = 0;
    curPc = 32'h1000; needNew = 0;

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("reset fe_done", {31'b0, fe_done}, 32'd0);
    checkOutput("reset mem_en", {31'b0, mem_en}, 32'd0);
    checkOutput("reset mem_pc", mem_pc, 32'h0);
    checkOutput("reset fe_inst", fe_inst, 32'h0);

    $display("[TB] cold miss");
    fetchOnce(32'h1000, cyc, men);
    checkOutput("cold fe_inst", fe_inst, 32'h0010_0093);
    checkOutput("cold mem_pc", mem_pc, 32'h0000_1000);
    checkOutput("cold latency", 32'(cyc), 32'd7);
    checkOutput("cold mem_en cycles", 32'(men), 32'd4);

    $display("[TB] hit");
    fetchOnce(32'h1000, cyc, men);
    checkOutput("hit latency", 32'(cyc), 32'd2);
    checkOutput("hit mem_en cycles", 32'(men), 32'd0);
    checkOutput("hit fe_inst", fe_inst, 32'h0010_0093);

    $display("[TB] conflict");
    fetchOnce(32'h1400, cyc, men);
    checkOutput("conflict mem_en cycles", 32'(men), 32'd4);
    checkOutput("conflict fe_inst", fe_inst, memWord(32'h1400));
    fetchOnce(32'h1000, cyc, men);
    checkOutput("refetch mem_en cycles", 32'(men), 32'd4);
    checkOutput("refetch fe_inst", fe_inst, 32'h0010_0093);

    $display("[TB] flush mid-miss");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h2000, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h2000, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h2000, 1'b0);
    doneCnt = 0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h2000, 1'b0);
      @(negedge clk);
      if (fe_done) doneCnt++;
      if (mem_en) cnt++;
    end
    checkOutput("flush fe_done count", 32'(doneCnt), 32'd0);
    checkOutput("flush mem_en after clr", 32'(cnt), 32'd2);
    fetchOnce(32'h2000, cyc, men);
    checkOutput("post-flush hit latency", 32'(cyc), 32'd2);
    checkOutput("post-flush mem_en cycles", 32'(men), 32'd0);
    checkOutput("post-flush fe_inst", fe_inst, memWord(32'h2000));

    $display("[TB] freeze during miss");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h3000, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h3000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h3000, 1'b0);
      @(negedge clk);
      checkOutput("freeze miss fe_done", {31'b0, fe_done}, 32'd0);
      checkOutput("freeze miss mem_en", {31'b0, mem_en}, 32'd0);
      checkOutput("freeze miss mem_pc", mem_pc, 32'h0000_3000);
    end
    fetchOnce(32'h3000, cyc, men);
    checkOutput("freeze miss fe_inst", fe_inst, memWord(32'h3000));

    $display("[TB] freeze during pending hit");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h3000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h3000, 1'b0);
      @(negedge clk);
      checkOutput("freeze hit fe_done", {31'b0, fe_done}, 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h3000, 1'b0);
    @(negedge clk);
    checkOutput("freeze hit delivered", {31'b0, fe_done}, 32'd1);
    checkOutput("freeze hit fe_inst", fe_inst, memWord(32'h3000));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h3000, 1'b0);

    $display("[TB] simultaneous clr and fe_en");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h4000, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h4000, 1'b0);
    @(negedge clk);
    checkOutput("clr+fe_en mem_en", {31'b0, mem_en}, 32'd0);
    checkOutput("clr+fe_en fe_done", {31'b0, fe_done}, 32'd0);

    $display("[TB] fe_en held across fe_done");
    pat = 4'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h3000, 1'b0);
      @(negedge clk);
      pat = {pat[2:0], fe_done};
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h3000, 1'b0);
    checkOutput("held fe_en pattern", {28'b0, pat}, 32'h5);

    $display("[TB] orphan mem_done");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h3000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h3000, 1'b0);
      @(negedge clk);
      checkOutput("orphan fe_done", {31'b0, fe_done}, 32'd0);
      checkOutput("orphan mem_en", {31'b0, mem_en}, 32'd0);
    end
    fetchOnce(32'h3000, cyc, men);
    checkOutput("orphan hit latency", 32'(cyc), 32'd2);
    checkOutput("orphan hit fe_inst", fe_inst, memWord(32'h3000));

    $display("[TB] randomized run");
    latMin = 0;
    latMax = 4;
    for (int i = 0; i < 3000; i++) begin
      if (needNew) curPc = randPc();
      rRst = ($urandom_range(0, 999) < 3);
      rRdy = ($urandom_range(0, 99) < 85);
      rClr = ($urandom_range(0, 99) < 5);
      rEn  = ($urandom_range(0, 99) < 80);
      rInj = ($urandom_range(0, 99) < 3);
      applyStimulus(rRst, rRdy, rClr, rEn, curPc, rInj);
      @(negedge clk);
      needNew = fe_done || rClr || rRst;
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, curPc, 1'b0);
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
